// File: rtl/running_add_pkg.sv
// Shared definitions for the running window adder: mode encodings,
// default parameter values and the minimum accumulator width helper.
package running_add_pkg;

  typedef enum logic {
    MODE_CUMULATIVE = 1'b0,
    MODE_SLIDING    = 1'b1
  } mode_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_WINDOW = 8;
  localparam int DEF_ACC_W  = 32;

  localparam int MIN_WINDOW = 2;
  localparam int MAX_WINDOW = 256;

  // Smallest accumulator that can hold WINDOW full-scale samples without wrap.
  function automatic int min_acc_w(input int data_w, input int window);
    return data_w + $clog2(window);
  endfunction

endpackage

// File: rtl/running_window_add_if.sv
// Sample-in / sum-out bundle for running_window_add.
// The master side drives samples and control; the slave side is the adder.
interface running_window_add_if #(
  parameter int DATA_W = running_add_pkg::DEF_DATA_W,
  parameter int ACC_W  = running_add_pkg::DEF_ACC_W
) ();

  logic [DATA_W-1:0] i_data;
  logic              i_data_valid;
  logic              i_mode;
  logic              i_clear;
  logic [ACC_W-1:0]  o_data;
  logic              o_data_valid;
  logic              o_window_full;
  logic              o_overflow;

  modport master (
    output i_data, i_data_valid, i_mode, i_clear,
    input  o_data, o_data_valid, o_window_full, o_overflow
  );

  modport slave (
    input  i_data, i_data_valid, i_mode, i_clear,
    output o_data, o_data_valid, o_window_full, o_overflow
  );

endinterface

// File: rtl/sample_ring.sv
// Circular sample buffer with a wrapping write pointer and a fill counter
// that saturates at WINDOW. The entry under the write pointer is the sample
// that is about to fall out of the window, so it is exposed as 'oldest'
// once the buffer is full and reads as zero before that.
module sample_ring #(
  parameter int DATA_W = running_add_pkg::DEF_DATA_W,
  parameter int WINDOW = running_add_pkg::DEF_WINDOW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] oldest,
  output logic              full
);

  localparam int PTR_W = $clog2(WINDOW);
  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WINDOW);

  logic [DATA_W-1:0] mem [WINDOW];
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fill_cnt;
  logic [PTR_W-1:0]  wr_idx;

  // A clear with a sample present restarts the ring with that sample in slot 0.
  assign wr_idx = clear ? '0 : wr_ptr;

  // Pointer wraps explicitly at WINDOW-1 so non-power-of-2 depths never skip a slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= push ? PTR_W'(1) : '0;
      fill_cnt <= push ? CNT_W'(1) : '0;
    end else if (push) begin
      wr_ptr   <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      fill_cnt <= (fill_cnt == FULL_CNT) ? fill_cnt : fill_cnt + CNT_W'(1);
    end
  end

  // Sample storage; stale contents are masked by the fill count, so no reset.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_idx] <= din;
    end
  end

  assign full   = (fill_cnt == FULL_CNT);
  assign oldest = full ? mem[wr_ptr] : '0;

endmodule

// File: rtl/running_window_add.sv
// Running adder over a sample stream: either a cumulative sum with sticky
// wrap detection, or the sum of the last WINDOW samples. One cycle latency.
// A change of mode behaves like a clear so the two sums never mix.
module running_window_add #(
  parameter int DATA_W = running_add_pkg::DEF_DATA_W,
  parameter int WINDOW = running_add_pkg::DEF_WINDOW,
  parameter int ACC_W  = running_add_pkg::DEF_ACC_W
) (
  input  logic               clock,
  input  logic               reset,
  running_window_add_if.slave bus
);

  import running_add_pkg::*;

  if (WINDOW < MIN_WINDOW || WINDOW > MAX_WINDOW) begin : g_bad_window
    $error("running_window_add: WINDOW out of range 2..256");
  end

  if (ACC_W < min_acc_w(DATA_W, WINDOW)) begin : g_bad_acc_w
    $error("running_window_add: ACC_W too narrow for DATA_W and WINDOW");
  end

  mode_e              mode_q;
  mode_e              mode_in;
  logic               eff_clear;
  logic [DATA_W-1:0]  ring_oldest;
  logic               ring_full;

  logic [ACC_W-1:0]   sum_q;
  logic [ACC_W-1:0]   data_q;
  logic               valid_q;
  logic               ovf_q;

  logic [ACC_W-1:0]   base;
  logic [ACC_W-1:0]   data_ext;
  logic [ACC_W-1:0]   sub_ext;
  logic [ACC_W:0]     wide;
  logic [ACC_W-1:0]   sum_next;
  logic               carry;

  assign mode_in   = mode_e'(bus.i_mode);
  assign eff_clear = bus.i_clear | (mode_in != mode_q);

  sample_ring #(
    .DATA_W (DATA_W),
    .WINDOW (WINDOW)
  ) u_ring (
    .clock  (clock),
    .reset  (reset),
    .clear  (eff_clear),
    .push   (bus.i_data_valid),
    .din    (bus.i_data),
    .oldest (ring_oldest),
    .full   (ring_full)
  );

  // Next sum; a clear in the same cycle makes the incoming sample the first one.
  always_comb begin
    base     = eff_clear ? '0 : sum_q;
    sub_ext  = eff_clear ? '0 : ACC_W'(ring_oldest);
    data_ext = ACC_W'(bus.i_data);
    wide     = {1'b0, base} + {1'b0, data_ext};
    sum_next = wide[ACC_W-1:0];
    carry    = wide[ACC_W];
    if (mode_in == MODE_SLIDING) begin
      sum_next = base + data_ext - sub_ext;
      carry    = 1'b0;
    end
  end

  // Accumulator, output register, mode register and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q  <= MODE_CUMULATIVE;
      sum_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mode_q  <= mode_in;
      valid_q <= bus.i_data_valid;
      if (bus.i_data_valid) begin
        sum_q  <= sum_next;
        data_q <= sum_next;
        ovf_q  <= (eff_clear ? 1'b0 : ovf_q) | carry;
      end else if (eff_clear) begin
        sum_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.o_data        = data_q;
  assign bus.o_data_valid  = valid_q;
  assign bus.o_window_full = ring_full;
  assign bus.o_overflow    = ovf_q;

endmodule

// File: tb/tb_running_window_add.sv
// Scoreboard bench for running_window_add. Four instances cover the window
// depths and accumulator widths of interest; only one is driven at a time,
// so a single ordered queue of expected outputs serves all of them.
module tb_running_window_add;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rst_q = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) rst_q <= reset;

  running_window_add_if #(.DATA_W(16), .ACC_W(32)) if_a ();
  running_window_add_if #(.DATA_W(16), .ACC_W(32)) if_b ();
  running_window_add_if #(.DATA_W(16), .ACC_W(32)) if_c ();
  running_window_add_if #(.DATA_W(16), .ACC_W(17)) if_d ();

  running_window_add #(.DATA_W(16), .WINDOW(4), .ACC_W(32)) u_a (.clock(clock), .reset(reset), .bus(if_a));
  running_window_add #(.DATA_W(16), .WINDOW(3), .ACC_W(32)) u_b (.clock(clock), .reset(reset), .bus(if_b));
  running_window_add #(.DATA_W(16), .WINDOW(5), .ACC_W(32)) u_c (.clock(clock), .reset(reset), .bus(if_c));
  running_window_add #(.DATA_W(16), .WINDOW(2), .ACC_W(17)) u_d (.clock(clock), .reset(reset), .bus(if_d));

  logic [15:0] drv_data  [4];
  logic        drv_valid [4];
  logic        drv_mode  [4];
  logic        drv_clear [4];

  logic [31:0] mon_data  [4];
  logic        mon_valid [4];
  logic        mon_full  [4];
  logic        mon_ovf   [4];

  assign if_a.i_data = drv_data[0]; assign if_a.i_data_valid = drv_valid[0];
  assign if_a.i_mode = drv_mode[0]; assign if_a.i_clear      = drv_clear[0];
  assign if_b.i_data = drv_data[1]; assign if_b.i_data_valid = drv_valid[1];
  assign if_b.i_mode = drv_mode[1]; assign if_b.i_clear      = drv_clear[1];
  assign if_c.i_data = drv_data[2]; assign if_c.i_data_valid = drv_valid[2];
  assign if_c.i_mode = drv_mode[2]; assign if_c.i_clear      = drv_clear[2];
  assign if_d.i_data = drv_data[3]; assign if_d.i_data_valid = drv_valid[3];
  assign if_d.i_mode = drv_mode[3]; assign if_d.i_clear      = drv_clear[3];

  assign mon_data[0] = if_a.o_data;           assign mon_valid[0] = if_a.o_data_valid;
  assign mon_full[0] = if_a.o_window_full;    assign mon_ovf[0]   = if_a.o_overflow;
  assign mon_data[1] = if_b.o_data;           assign mon_valid[1] = if_b.o_data_valid;
  assign mon_full[1] = if_b.o_window_full;    assign mon_ovf[1]   = if_b.o_overflow;
  assign mon_data[2] = if_c.o_data;           assign mon_valid[2] = if_c.o_data_valid;
  assign mon_full[2] = if_c.o_window_full;    assign mon_ovf[2]   = if_c.o_overflow;
  assign mon_data[3] = {15'b0, if_d.o_data};  assign mon_valid[3] = if_d.o_data_valid;
  assign mon_full[3] = if_d.o_window_full;    assign mon_ovf[3]   = if_d.o_overflow;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        full;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_data [4];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per output strobe, checks reset values and data hold.
  always @(negedge clock) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (rst_q) begin
        chk("rst_valid", k, 32'(mon_valid[k]), 0);
        chk("rst_data",  k, mon_data[k], 0);
        chk("rst_full",  k, 32'(mon_full[k]), 0);
        chk("rst_ovf",   k, 32'(mon_ovf[k]), 0);
        last_data[k] = '0;
      end else if (mon_valid[k]) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", k, 1, 0);
        end else begin
          e = sb.pop_front();
          chk("dut_index", k, k, e.idx);
          chk("data",      k, mon_data[k], e.data);
          chk("full",      k, 32'(mon_full[k]), 32'(e.full));
          chk("ovf",       k, 32'(mon_ovf[k]), 32'(e.ovf));
        end
        last_data[k] = mon_data[k];
      end else begin
        chk("hold", k, mon_data[k], last_data[k]);
      end
    end
  end

  // One accepted sample with its expected output.
  task automatic put(input int k, input logic [15:0] d, input logic m, input logic c,
                     input logic [31:0] ed, input logic ef, input logic eo);
    exp_t e;
    drv_data[k]  = d;
    drv_mode[k]  = m;
    drv_clear[k] = c;
    drv_valid[k] = 1'b1;
    e.idx = k; e.data = ed; e.full = ef; e.ovf = eo;
    sb.push_back(e);
    @(posedge clock); #1;
    drv_valid[k] = 1'b0;
    drv_clear[k] = 1'b0;
  endtask

  task automatic clear_only(input int k);
    drv_clear[k] = 1'b1;
    @(posedge clock); #1;
    drv_clear[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  // Reset pulse with a sample offered on dut 0 that must be discarded.
  task automatic reset_with_sample(input logic m);
    reset        = 1'b1;
    drv_data[0]  = 16'd5;
    drv_mode[0]  = m;
    drv_valid[0] = 1'b1;
    @(posedge clock); #1;
    drv_valid[0] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  int slide4 [10] = '{1, 3, 6, 10, 14, 18, 22, 26, 30, 34};
  int cum10  [10] = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55};

  initial begin
    for (int k = 0; k < 4; k++) begin
      drv_data[k] = '0; drv_valid[k] = 1'b0; drv_mode[k] = 1'b0; drv_clear[k] = 1'b0;
      last_data[k] = '0;
    end
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);

    // Window 4, sliding, 1..10
    for (int i = 0; i < 10; i++)
      put(0, 16'(i + 1), 1'b1, 1'b0, 32'(slide4[i]), (i >= 3), 1'b0);
    idle(2);

    // Window 4, cumulative, 1..10 (mode change restarts)
    for (int i = 0; i < 10; i++)
      put(0, 16'(i + 1), 1'b0, 1'b0, 32'(cum10[i]), (i >= 3), 1'b0);
    idle(1);

    // Clear without a sample, then restart
    clear_only(0);
    chk("clear_full", 0, 32'(mon_full[0]), 0);
    put(0, 16'd5, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0);
    idle(2);

    // Window 3, sliding, clear with sample, then pointer wrap
    put(1, 16'd4,  1'b1, 1'b0, 32'd4,  1'b0, 1'b0);
    put(1, 16'd5,  1'b1, 1'b0, 32'd9,  1'b0, 1'b0);
    put(1, 16'd6,  1'b1, 1'b0, 32'd15, 1'b1, 1'b0);
    put(1, 16'd7,  1'b1, 1'b1, 32'd7,  1'b0, 1'b0);
    put(1, 16'd8,  1'b1, 1'b0, 32'd15, 1'b0, 1'b0);
    put(1, 16'd9,  1'b1, 1'b0, 32'd24, 1'b1, 1'b0);
    put(1, 16'd10, 1'b1, 1'b0, 32'd27, 1'b1, 1'b0);
    put(1, 16'd11, 1'b1, 1'b0, 32'd30, 1'b1, 1'b0);
    idle(2);

    // Window 5, sliding, with idle gaps
    put(2, 16'd1, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
    idle(3);
    put(2, 16'd2, 1'b1, 1'b0, 32'd3, 1'b0, 1'b0);
    idle(3);
    put(2, 16'd3, 1'b1, 1'b0, 32'd6,  1'b0, 1'b0);
    put(2, 16'd4, 1'b1, 1'b0, 32'd10, 1'b0, 1'b0);
    put(2, 16'd5, 1'b1, 1'b0, 32'd15, 1'b1, 1'b0);
    put(2, 16'd6, 1'b1, 1'b0, 32'd20, 1'b1, 1'b0);
    idle(2);

    // 17-bit accumulator, window 2: wrap, sticky overflow, clear, mode change
    put(3, 16'd65535, 1'b0, 1'b0, 32'd65535,  1'b0, 1'b0);
    put(3, 16'd65535, 1'b0, 1'b0, 32'd131070, 1'b1, 1'b0);
    put(3, 16'd2,     1'b0, 1'b0, 32'd0,      1'b1, 1'b1);
    put(3, 16'd5,     1'b0, 1'b0, 32'd5,      1'b1, 1'b1);
    clear_only(3);
    chk("clear_ovf",  3, 32'(mon_ovf[3]), 0);
    chk("clear_full", 3, 32'(mon_full[3]), 0);
    put(3, 16'd3,     1'b0, 1'b0, 32'd3,      1'b0, 1'b0);
    put(3, 16'd65535, 1'b0, 1'b0, 32'd65538,  1'b1, 1'b0);
    put(3, 16'd65535, 1'b0, 1'b0, 32'd1,      1'b1, 1'b1);
    put(3, 16'd65535, 1'b1, 1'b0, 32'd65535,  1'b0, 1'b0);
    put(3, 16'd65535, 1'b1, 1'b0, 32'd131070, 1'b1, 1'b0);
    put(3, 16'd65535, 1'b1, 1'b0, 32'd131070, 1'b1, 1'b0);
    put(3, 16'd1,     1'b1, 1'b0, 32'd65536,  1'b1, 1'b0);
    idle(2);

    // Reset mid-stream, sliding then cumulative
    put(0, 16'd9, 1'b1, 1'b0, 32'd9,  1'b0, 1'b0);
    put(0, 16'd9, 1'b1, 1'b0, 32'd18, 1'b0, 1'b0);
    reset_with_sample(1'b1);
    put(0, 16'd1, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
    idle(2);
    put(0, 16'd9, 1'b0, 1'b0, 32'd9,  1'b0, 1'b0);
    put(0, 16'd9, 1'b0, 1'b0, 32'd18, 1'b0, 1'b0);
    reset_with_sample(1'b0);
    put(0, 16'd1, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    for (int n = 0; n < 20 && sb.size() != 0; n++) idle(1);
    idle(2);
    chk("drain_left", 0, 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/running_window_add.md
RUNNING_WINDOW_ADD -- requirements
Module: running_window_add

Interface
REQ-001 Parameter DATA_W, default 16: unsigned input sample width.
REQ-002 Parameter WINDOW, default 8: sliding-window depth in samples; legal range 2..256.
REQ-003 Parameter ACC_W, default 32: accumulator and output width; elaboration SHALL fail if ACC_W < DATA_W + clog2(WINDOW).
REQ-004 clock  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 i_data  in  DATA_W  unsigned sample.
REQ-007 i_data_valid  in  1  sample qualifier; one sample per cycle when high.
REQ-008 i_mode  in  1  0 = cumulative running sum, 1 = sliding-window sum.
REQ-009 i_clear  in  1  synchronous soft clear of sum, buffer and flags.
REQ-010 o_data  out  ACC_W  registered sum.
REQ-011 o_data_valid  out  1  one-cycle strobe per accepted sample.
REQ-012 o_window_full  out  1  high once WINDOW samples have been accepted since the last clear.
REQ-013 o_overflow  out  1  sticky; cumulative-mode wrap has occurred.

Function
REQ-014 Latency SHALL be exactly 1 cycle: a sample accepted at edge N produces o_data/o_data_valid at edge N+1; back-to-back samples SHALL produce back-to-back outputs.
REQ-015 o_data_valid SHALL be low in every cycle that follows a cycle with i_data_valid low; o_data SHALL hold its last value while o_data_valid is low.
REQ-016 Cumulative mode: sum_next = sum + i_data modulo 2^ACC_W; a carry out of bit ACC_W-1 SHALL set o_overflow until the next clear, mode change or reset.
REQ-017 Sliding mode: sum_next = sum + i_data - oldest, where oldest is the sample written WINDOW accepted samples earlier, and is 0 while the fill count is below WINDOW.
REQ-018 Every accepted sample SHALL be written into a WINDOW-entry circular buffer in both modes; the write pointer SHALL wrap from WINDOW-1 to 0, with no skipped or repeated entries for non-power-of-2 WINDOW.
REQ-019 The fill count SHALL saturate at WINDOW; o_window_full SHALL equal (fill count == WINDOW) and SHALL assert in the same cycle as the output for the WINDOW-th sample.
REQ-020 Gaps in i_data_valid SHALL NOT advance the pointer, the count or the sum.
REQ-021 i_clear high SHALL zero the sum, pointer, fill count, o_window_full and o_overflow; if i_data_valid is also high, that sample SHALL be treated as the first sample after the clear, so o_data = i_data.
REQ-022 A change of i_mode relative to the registered mode SHALL act as an implicit i_clear in the same cycle, and the new mode SHALL apply to any sample present in that cycle.
REQ-023 In sliding mode o_overflow SHALL never assert, because ACC_W is sized for it.

Reset
REQ-024 reset SHALL force o_data = 0, o_data_valid = 0, o_window_full = 0, o_overflow = 0, pointer = 0, fill count = 0 and registered mode = 0.
REQ-025 reset SHALL take priority over i_clear and i_data_valid; a sample present in the reset cycle SHALL be discarded.
REQ-026 Buffer contents need no reset; the fill count gating in REQ-017 SHALL make stale entries unobservable.

Structure
REQ-027 Package running_add_pkg SHALL hold the mode encodings (MODE_CUMULATIVE = 0, MODE_SLIDING = 1) and the default parameter values.
REQ-028 Sub-module sample_ring SHALL implement the circular buffer, write pointer and saturating fill counter, and expose the oldest sample and a full flag; the top SHALL hold the accumulator, the mode register and the flags.

Verification
REQ-029 Sliding mode, WINDOW=4, contiguous inputs 1..10 -> o_data 1,3,6,10,14,18,22,26,30,34; o_window_full rises on the 4th output.
REQ-030 Cumulative mode, inputs 1..10 -> o_data 1,3,6,10,15,21,28,36,45,55; o_overflow stays 0.
REQ-031 Cumulative mode, ACC_W=17, DATA_W=16: inputs 65535,65535,2 -> o_data 65535,131070,0; o_overflow = 1 from the 3rd output; then i_clear -> o_overflow = 0.
REQ-032 Sliding mode, WINDOW=3: inputs 4,5,6, then i_clear together with valid 7, then 8 -> o_data 4,9,15,7,15; o_window_full = 0 after the clear.
REQ-033 Sliding mode, WINDOW=5: inputs 1,2 with 3 idle cycles between samples, then 3,4,5,6 -> o_data 1,3,6,10,15,20; o_data_valid low and o_data held during the gaps.
REQ-034 Assert reset after inputs 9,9, then apply input 1 -> all outputs 0 during reset; first output after reset = 1 in both modes.
